// File: rtl/dynamic_multi2_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dynamic_multi2_pkg : shared defaults and FSM encoding for dynamic_multi2
// Revision: 1.0
// ----------------------------------------------------------------------------
package dynamic_multi2_pkg;

  localparam int DM2_DATA_W = 32;
  localparam int DM2_DEPTH  = 8;
  localparam int DM2_PTR_W  = $clog2(DM2_DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage : dynamic_multi2_pkg
`default_nettype wire

// File: rtl/dm2_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dm2_fifo : synchronous FIFO, combinational head, registered full flag
// Revision: 1.0
// ----------------------------------------------------------------------------
module dm2_fifo
  import dynamic_multi2_pkg::*;
#(
  parameter int W     = DM2_DATA_W,
  parameter int DEPTH = DM2_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             full_q;
  logic             do_push, do_pop;

  // A full FIFO drops the push even when a pop frees a slot in the same edge.
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == (PTR_W+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = (count_q == '0);

endmodule : dm2_fifo
`default_nettype wire

// File: rtl/dynamic_multi2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dynamic_multi2 : dual-FIFO buffered shift-add multiplier, operand-dependent latency
// Revision: 1.0
// ----------------------------------------------------------------------------
module dynamic_multi2
  import dynamic_multi2_pkg::*;
#(
  parameter int DATA_W = DM2_DATA_W,
  parameter int DEPTH  = DM2_DEPTH
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] dataIn0,
  input  logic [DATA_W-1:0] dataIn1,
  input  logic              bufferRD,
  input  logic              bufferEN,
  input  logic              mStart,
  output logic              mReady,
  output logic [DATA_W-1:0] dataOutMSB,
  output logic [DATA_W-1:0] dataOutLSB,
  output logic              FULL0,
  output logic              FULL1
);

  state_e                state_q, state_d;
  logic [2*DATA_W-1:0]   a_q, a_d, p_q, p_d, p_sum;
  logic [DATA_W-1:0]     b_q, b_d, msb_q, msb_d, lsb_q, lsb_d;
  logic [DATA_W-1:0]     head0, head1;
  logic                  empty0, empty1;
  logic                  push, accept;

  assign push   = bufferEN && !bufferRD;
  assign accept = mStart && (state_q == IDLE) && !empty0 && !empty1;

  dm2_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
    .clk_i  (Clk),
    .rst_ni (Rst),
    .push_i (push),
    .pop_i  (accept),
    .din_i  (dataIn0),
    .dout_o (head0),
    .full_o (FULL0),
    .empty_o(empty0)
  );

  dm2_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
    .clk_i  (Clk),
    .rst_ni (Rst),
    .push_i (push),
    .pop_i  (accept),
    .din_i  (dataIn1),
    .dout_o (head1),
    .full_o (FULL1),
    .empty_o(empty1)
  );

  assign p_sum = b_q[0] ? (p_q + a_q) : p_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    msb_d   = msb_q;
    lsb_d   = lsb_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = {{DATA_W{1'b0}}, head0};
          b_d     = head1;
          p_d     = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        p_d = p_sum;
        a_d = a_q << 1;
        b_d = b_q >> 1;
        // Stop once no multiplier bits remain; B=0 still takes one pass.
        if ((b_q >> 1) == '0) begin
          {msb_d, lsb_d} = p_sum;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      msb_q   <= '0;
      lsb_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      msb_q   <= msb_d;
      lsb_q   <= lsb_d;
    end
  end

  assign mReady     = (state_q == IDLE);
  assign dataOutMSB = msb_q;
  assign dataOutLSB = lsb_q;

endmodule : dynamic_multi2
`default_nettype wire

// File: tb/tb_dynamic_multi2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dynamic_multi2 : self-checking bench with operand/result scoreboard
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_dynamic_multi2;

  localparam int W = 32;
  localparam int D = 8;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic [W-1:0] dataIn0 = '0, dataIn1 = '0;
  logic         bufferRD = 1'b0, bufferEN = 1'b0, mStart = 1'b0;
  logic         mReady, FULL0, FULL1;
  logic [W-1:0] dataOutMSB, dataOutLSB;

  dynamic_multi2 #(.DATA_W(W), .DEPTH(D)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .dataIn0   (dataIn0),
    .dataIn1   (dataIn1),
    .bufferRD  (bufferRD),
    .bufferEN  (bufferEN),
    .mStart    (mStart),
    .mReady    (mReady),
    .dataOutMSB(dataOutMSB),
    .dataOutLSB(dataOutLSB),
    .FULL0     (FULL0),
    .FULL1     (FULL1)
  );

  always #5 Clk = ~Clk;

  int passed = 0;
  int total  = 0;

  logic [W-1:0]   mq0[$], mq1[$];
  logic [2*W-1:0] sb[$];
  logic [2*W-1:0] m_out = '0;
  bit             m_busy = 1'b0;
  int             m_cnt = 0;

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int iters(input logic [W-1:0] b);
    int n = 1;
    for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  // One clock: advance the reference model with the inputs in force, then compare.
  task automatic cyc();
    bit f0, f1, acc, fin;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] e;
    fin = 1'b0;
    if (!Rst) begin
      mq0.delete(); mq1.delete(); sb.delete();
      m_busy = 1'b0; m_out = '0;
    end else begin
      f0  = (mq0.size() == D);
      f1  = (mq1.size() == D);
      acc = mStart && !m_busy && mq0.size() > 0 && mq1.size() > 0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin m_busy = 1'b0; fin = 1'b1; end
      end else if (acc) begin
        a = mq0.pop_front();
        b = mq1.pop_front();
        sb.push_back(64'(a) * 64'(b));
        m_busy = 1'b1;
        m_cnt  = iters(b);
      end
      if (bufferEN && !bufferRD) begin
        if (!f0) mq0.push_back(dataIn0);
        if (!f1) mq1.push_back(dataIn1);
      end
    end
    @(posedge Clk); #1;
    if (fin && sb.size() > 0) begin
      e = sb.pop_front();
      m_out = e;
      check("result", {dataOutMSB, dataOutLSB}, e);
    end
    check("mReady", 64'(mReady), 64'(!m_busy));
    check("FULL0", 64'(FULL0), 64'(mq0.size() == D));
    check("FULL1", 64'(FULL1), 64'(mq1.size() == D));
    check("dataOut", {dataOutMSB, dataOutLSB}, m_out);
  endtask

  task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    bufferEN = 1'b1; bufferRD = 1'b0; dataIn0 = a; dataIn1 = b;
    cyc();
    bufferEN = 1'b0;
  endtask

  task automatic start();
    mStart = 1'b1;
    cyc();
    mStart = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (m_busy && n < 200) begin cyc(); n++; end
    if (m_busy) check("timeout", 64'(1), 64'(0));
  endtask

  int n;

  initial begin
    // Reset and ignored start on empty FIFOs
    Rst = 1'b0; cyc(); cyc();
    Rst = 1'b1; cyc();
    check("rst_mReady", 64'(mReady), 64'(1));
    check("rst_out", {dataOutMSB, dataOutLSB}, 64'(0));
    start();
    check("empty_start", 64'(mReady), 64'(1));

    // Basic: 4*8 (4 iterations), then 8*12 (4 iterations)
    push_pair(32'd4, 32'd8);
    start();
    wait_done(n);
    check("basic1_cycles", 64'(n), 64'(4));
    check("basic1", {dataOutMSB, dataOutLSB}, 64'd32);
    push_pair(32'd8, 32'd12);
    start();
    wait_done(n);
    check("basic2_cycles", 64'(n), 64'(4));
    check("basic2", {dataOutMSB, dataOutLSB}, 64'd96);

    // Fill: ten pushes, last two dropped
    bufferEN = 1'b1; dataIn0 = 32'd5; dataIn1 = 32'd6;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (i == 6) check("full_early", 64'({FULL0, FULL1}), 64'(0));
      if (i == 7) check("full_8th", 64'({FULL0, FULL1}), 64'(3));
    end
    bufferEN = 1'b0;
    start();
    check("full_fall", 64'({FULL0, FULL1}), 64'(0));
    wait_done(n);
    check("fill_res", {dataOutMSB, dataOutLSB}, 64'd30);
    while (mq0.size() > 0) begin start(); wait_done(n); end

    // Inhibit and FIFO order
    push_pair(32'd3, 32'd5);
    push_pair(32'd7, 32'd2);
    bufferEN = 1'b1; bufferRD = 1'b1; dataIn0 = 32'd99; dataIn1 = 32'd99;
    start(); wait_done(n);
    check("order1", {dataOutMSB, dataOutLSB}, 64'd15);
    start(); wait_done(n);
    check("order2", {dataOutMSB, dataOutLSB}, 64'd14);
    start();
    check("inhibit_empty", 64'(mReady), 64'(1));
    bufferEN = 1'b0; bufferRD = 1'b0;

    // Extremes, plus a start while busy that must be ignored
    push_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    start();
    push_pair(32'h1234, 32'h0);
    start();
    check("busy_ignored", 64'(mReady), 64'(0));
    wait_done(n);
    check("max_cycles", 64'(n + 2), 64'(32));
    check("max_res", {dataOutMSB, dataOutLSB}, 64'hFFFF_FFFE_0000_0001);
    start();
    wait_done(n);
    check("zero_cycles", 64'(n), 64'(1));
    check("zero_res", {dataOutMSB, dataOutLSB}, 64'd0);
    push_pair(32'd3, 32'd3);
    start(); wait_done(n);
    check("nonzero_res", {dataOutMSB, dataOutLSB}, 64'd9);

    // Reset mid-operation
    push_pair(32'd9, 32'h8000_0000);
    start();
    repeat (5) cyc();
    Rst = 1'b0; cyc();
    Rst = 1'b1;
    check("midrst_mReady", 64'(mReady), 64'(1));
    check("midrst_out", {dataOutMSB, dataOutLSB}, 64'd0);
    start();
    check("midrst_empty", 64'(mReady), 64'(1));
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_dynamic_multi2
`default_nettype wire
